// File: rtl/video_de_gen.sv
// Data-enable generator for a scan-doubled video stream: tracks hsync/vsync,
// locks onto a stable line period and emits aligned de/syncs/expanded colour.
module video_de_gen #(
  parameter int H_START    = 48,
  parameter int H_ACTIVE   = 640,
  parameter int V_START    = 33,
  parameter int V_ACTIVE   = 480,
  parameter int LOCK_LINES = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic       de,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       locked
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [10:0] HPOS_MAX = 11'h7FF;
  localparam logic [9:0]  VPOS_MAX = 10'h3FF;
  localparam logic [11:0] H_LO     = 12'(H_START);
  localparam logic [11:0] H_HI     = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO     = 11'(V_START);
  localparam logic [10:0] V_HI     = 11'(V_START + V_ACTIVE);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_LINES);

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic        vs_pend_q, vs_pend_d;
  logic [10:0] hpos_q, hpos_d;
  logic [9:0]  vpos_q, vpos_d;
  logic [10:0] per_cnt_q, per_cnt_d;
  logic [10:0] prev_per_q, prev_per_d;
  logic        ref_vld_q, ref_vld_d;
  logic [7:0]  match_q, match_d;
  logic        hs_out_q, hs_out_d, vs_out_q, vs_out_d;
  logic        de_q, de_d, locked_q, locked_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  logic        hs_rise, hs_fall, vs_rise, per_ok, in_area;
  logic [10:0] per_new, per_diff;
  logic [7:0]  match_inc;

  assign hs_rise   = hs_in & ~hs_prev_q;
  assign hs_fall   = ~hs_in & hs_prev_q;
  assign vs_rise   = vs_in & ~vs_prev_q;
  assign per_new   = (per_cnt_q == HPOS_MAX) ? HPOS_MAX : per_cnt_q + 11'd1;
  assign per_diff  = (per_new >= prev_per_q) ? per_new - prev_per_q : prev_per_q - per_new;
  assign per_ok    = (per_diff <= 11'd1);
  assign match_inc = match_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    hs_prev_d  = hs_prev_q;
    vs_prev_d  = vs_prev_q;
    vs_pend_d  = vs_pend_q;
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    per_cnt_d  = per_cnt_q;
    prev_per_d = prev_per_q;
    ref_vld_d  = ref_vld_q;
    match_d    = match_q;
    hs_out_d   = hs_out_q;
    vs_out_d   = vs_out_q;
    de_d       = de_q;
    locked_d   = locked_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    in_area    = 1'b0;
    if (ce_pix) begin
      hs_prev_d = hs_in;
      vs_prev_d = vs_in;
      hpos_d    = hs_rise ? 11'd0 : ((hpos_q == HPOS_MAX) ? HPOS_MAX : hpos_q + 11'd1);
      // A vsync rise arms the next hsync rise (same sample included) as line 0.
      if (hs_rise) begin
        vpos_d    = (vs_pend_q | vs_rise) ? 10'd0 :
                    ((vpos_q == VPOS_MAX) ? VPOS_MAX : vpos_q + 10'd1);
        vs_pend_d = 1'b0;
      end else if (vs_rise) begin
        vs_pend_d = 1'b1;
      end
      per_cnt_d = hs_fall ? 11'd0 : per_new;

      if (hs_fall) begin
        prev_per_d = per_new;
        case (state_q)
          SEARCH: begin
            state_d   = TRACK;
            match_d   = 8'd0;
            ref_vld_d = 1'b0;
          end
          TRACK: begin
            // First period after SEARCH has nothing to contradict it: it is the reference.
            if (!ref_vld_q || per_ok) match_d = match_inc;
            else                      match_d = 8'd0;
            ref_vld_d = 1'b1;
            if ((!ref_vld_q || per_ok) && match_inc >= LOCK_N) state_d = LOCKED;
          end
          default: begin
            if (!per_ok) begin
              state_d = TRACK;
              match_d = 8'd0;
            end
          end
        endcase
      end else if (per_new == HPOS_MAX) begin
        state_d = SEARCH;
      end

      in_area  = ({1'b0, hpos_d} >= H_LO) && ({1'b0, hpos_d} < H_HI) &&
                 ({1'b0, vpos_d} >= V_LO) && ({1'b0, vpos_d} < V_HI);
      locked_d = (state_d == LOCKED);
      de_d     = locked_d && in_area;
      hs_out_d = hs_in;
      vs_out_d = vs_in;
      r_d      = de_d ? {r_in, r_in[5:4]} : 8'h00;
      g_d      = de_d ? {g_in, g_in[5:4]} : 8'h00;
      b_d      = de_d ? {b_in, b_in[5:4]} : 8'h00;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= SEARCH;
      hs_prev_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      vs_pend_q  <= 1'b0;
      hpos_q     <= 11'd0;
      vpos_q     <= 10'd0;
      per_cnt_q  <= 11'd0;
      prev_per_q <= 11'd0;
      ref_vld_q  <= 1'b0;
      match_q    <= 8'd0;
      hs_out_q   <= 1'b1;
      vs_out_q   <= 1'b1;
      de_q       <= 1'b0;
      locked_q   <= 1'b0;
      r_q        <= 8'h00;
      g_q        <= 8'h00;
      b_q        <= 8'h00;
    end else begin
      state_q    <= state_d;
      hs_prev_q  <= hs_prev_d;
      vs_prev_q  <= vs_prev_d;
      vs_pend_q  <= vs_pend_d;
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      per_cnt_q  <= per_cnt_d;
      prev_per_q <= prev_per_d;
      ref_vld_q  <= ref_vld_d;
      match_q    <= match_d;
      hs_out_q   <= hs_out_d;
      vs_out_q   <= vs_out_d;
      de_q       <= de_d;
      locked_q   <= locked_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign hs_out = hs_out_q;
  assign vs_out = vs_out_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign r_out  = r_q;
  assign g_out  = g_q;
  assign b_out  = b_q;

endmodule
